cluster_sched: RTL and testbench
================================

# cluster_sched

Sequencing front-end for a cluster of sparse compute units. It replaces static filter write-order selection and output-buffer muxing with a self-running job controller. Each job:
- steers a filter stream round-robin into `UNIT_NUM` units,
- launches a chunk run and waits for every unit's chunk-end,
- drains one output word per unit over a valid/ready stream,
- toggles the accumulation buffer.

It sits between the cluster's host-side filter/output ports and the compute-unit array.

## Interface
Parameters:
- `UNIT_NUM`, 8, number of compute units (≥2).
- `BUS_SIZE`, 32, sparsemap bits per filter beat; data is `BUS_SIZE*8` bits.
- `WR_BEATS`, 4, filter beats per unit per job (≥1).
- `OUT_BUF_NUM`, 2, accumulation/output buffers per unit (power of two).
- `OUT_W`, 32, output word width.

Ports (widths `UW`=`$clog2(UNIT_NUM)`, `BW`=`$clog2(WR_BEATS)` (min 1), `OBW`=`$clog2(OUT_BUF_NUM)`):
- `clk_i`, in, 1, clock.
- `rst_i`, in, 1, asynchronous active-low reset.
- `start_i`, in, 1, job start pulse; ignored unless IDLE.
- `busy_o`, out, 1, high in any state but IDLE.
- `done_o`, out, 1, one-cycle job-complete pulse.
- `flt_valid_i`, in, 1, filter beat valid.
- `flt_ready_o`, out, 1, filter beat ready.
- `flt_sparsemap_i`, in, `BUS_SIZE`, filter sparsemap beat.
- `flt_data_i`, in, `BUS_SIZE*8`, filter nonzero data beat.
- `unit_flt_valid_o`, out, `UNIT_NUM`, one-hot per-unit write strobe (registered).
- `unit_flt_count_o`, out, `BW`, beat index within unit.
- `unit_flt_sparsemap_o`, out, `BUS_SIZE`, registered sparsemap.
- `unit_flt_data_o`, out, `BUS_SIZE*8`, registered data.
- `run_valid_o`, out, 1, run enable to all units.
- `chunk_start_o`, out, 1, one-cycle chunk start.
- `unit_chunk_end_i`, in, `UNIT_NUM`, per-unit chunk end (level or pulse).
- `acc_buf_sel_o`, out, `OBW`, buffer being accumulated.
- `unit_out_buf_sel_o`, out, `OBW`, buffer being drained.
- `unit_out_dat_i`, in, `UNIT_NUM*OUT_W`, per-unit output word.
- `out_valid_o`, out, 1, drain stream valid.
- `out_ready_i`, in, 1, drain stream ready.
- `out_dat_o`, out, `OUT_W`, drain data.
- `out_unit_o`, out, `UW`, source unit of `out_dat_o`.

## Operation
- **States:** IDLE → LOAD → RUN → DRAIN → DONE → IDLE.
- **IDLE.** `start_i` moves the block to LOAD and clears the unit index `u` and beat counter `b`.
- **LOAD.** `flt_ready_o`=1.
  - Each accepted beat (`flt_valid_i & flt_ready_o`) sets `unit_flt_valid_o[u]` for one cycle, with `unit_flt_count_o`=`b` and the sparsemap/data registered.
  - `b` increments; at `WR_BEATS-1` it wraps to 0 and `u` increments.
  - Acceptance of beat (`UNIT_NUM-1`, `WR_BEATS-1`) moves the block to RUN.
- **RUN.**
  - Sticky end bits clear on entry.
  - `chunk_start_o` pulses in the first RUN cycle; `run_valid_o`=1 throughout RUN.
  - `unit_chunk_end_i[k]` sets sticky bit k in every RUN cycle, including the first.
  - When all bits are set, the block goes to DRAIN the next cycle.
- **DRAIN.**
  - `out_valid_o`=1.
  - `out_dat_o` = `unit_out_dat_i[u]`, `out_unit_o`=`u`; combinational mux, `u` cleared on entry.
  - Each handshake increments `u`; the handshake at `UNIT_NUM-1` moves the block to DONE.
  - `unit_out_buf_sel_o` equals `acc_buf_sel_o` for the job being drained.
- **DONE.**
  - `done_o`=1 for one cycle.
  - `acc_buf_sel_o` increments modulo `OUT_BUF_NUM`.
  - The block returns to IDLE.
- **Counter widths.** Counters are sized exactly; indices never exceed `UNIT_NUM-1` / `WR_BEATS-1`.

## Timing
- **Reset values.** All outputs 0: `acc_buf_sel_o`=0, `unit_out_buf_sel_o`=0, `out_unit_o`=0, `busy_o`=0, state IDLE.
- **Mid-job reset.** Asserting `rst_i` mid-job returns the block to IDLE immediately; no partial write strobes follow.
- **start_i.** From `start_i` to `flt_ready_o`: 1 cycle.
- **Filter path.** From accepted beat to `unit_flt_valid_o`: 1 cycle.
- **LOAD → RUN.**
  - From the last accepted beat to `chunk_start_o`/`run_valid_o`: 2 cycles (the last unit strobe lands the cycle before RUN).
  - `flt_ready_o` is 0 from the cycle after the last beat.
- **RUN → DRAIN.** From the cycle all end bits are set to `out_valid_o`: 1 cycle; `run_valid_o` falls in the same cycle `out_valid_o` rises.
- **Drain stream.**
  - `out_valid_o` stays high without `out_ready_i`; data and unit are held stable.
  - Back-to-back handshakes yield one word per cycle.
- **Job cadence.** `start_i` during DONE is ignored; a new job starts no earlier than the cycle after DONE.

## Configuration
- **`CLUSTER_UNIT_MASK_EN` defined.** Adds input `unit_mask_i` [`UNIT_NUM`], sampled at `start_i`.
  - Masked units receive no filter beats: LOAD expects `WR_BEATS` × (number of unmasked units) beats.
  - Masked units are treated as chunk-ended and are skipped in DRAIN.
  - An all-zero mask makes the job go IDLE → DONE in 2 cycles with no stream activity.
- **Macro undefined.** All units are active; behaviour is exactly as above.

## Test plan
- **Single job, full flow.** Reset; `start_i`; stream 32 beats with `flt_valid_i` held high (`UNIT_NUM`=8, `WR_BEATS`=4) → `unit_flt_valid_o` walks 0x01..0x80, four strobes each, with `unit_flt_count_o` 0,1,2,3; `chunk_start_o` fires once, 2 cycles after the last beat.
- **Staggered chunk ends.** Units 0–6 end in RUN cycle 1; unit 7 ends in cycle 9 → `out_valid_o` rises in cycle 10; `run_valid_o` low from cycle 10.
- **Drain with backpressure.** `unit_out_dat_i[k]`=0x100+k; `out_ready_i` alternating 1/0 → 8 words 0x100..0x107 in order, stable while stalled; `done_o` pulses once; `acc_buf_sel_o` 0→1, and 1→0 on a second job.
- **Reset mid-LOAD.** Assert `rst_i` low after 10 beats → all outputs 0 asynchronously; a new job then needs the full 32 beats.
- **Mask mode** (`CLUSTER_UNIT_MASK_EN`). `unit_mask_i`=0x0F → 16 beats accepted; no strobes to units 4–7; drain emits units 0–3 only.

Source files
------------

// File: rtl/cluster_sched.sv
// rtl/cluster_sched.sv - cluster job sequencer: filter steering, chunk run, output drain, buffer toggle
// Optional per-unit masking is enabled by defining CLUSTER_UNIT_MASK_EN.
module cluster_sched #(
  parameter int UNIT_NUM    = 8,
  parameter int BUS_SIZE    = 32,
  parameter int WR_BEATS    = 4,
  parameter int OUT_BUF_NUM = 2,
  parameter int OUT_W       = 32,
  localparam int UW  = $clog2(UNIT_NUM),
  localparam int BW  = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1,
  localparam int OBW = (OUT_BUF_NUM > 1) ? $clog2(OUT_BUF_NUM) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
`ifdef CLUSTER_UNIT_MASK_EN
  input  logic [UNIT_NUM-1:0]       unit_mask_i,
`endif
  output logic                      busy_o,
  output logic                      done_o,
  input  logic                      flt_valid_i,
  output logic                      flt_ready_o,
  input  logic [BUS_SIZE-1:0]       flt_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]     flt_data_i,
  output logic [UNIT_NUM-1:0]       unit_flt_valid_o,
  output logic [BW-1:0]             unit_flt_count_o,
  output logic [BUS_SIZE-1:0]       unit_flt_sparsemap_o,
  output logic [BUS_SIZE*8-1:0]     unit_flt_data_o,
  output logic                      run_valid_o,
  output logic                      chunk_start_o,
  input  logic [UNIT_NUM-1:0]       unit_chunk_end_i,
  output logic [OBW-1:0]            acc_buf_sel_o,
  output logic [OBW-1:0]            unit_out_buf_sel_o,
  input  logic [UNIT_NUM*OUT_W-1:0] unit_out_dat_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [OUT_W-1:0]          out_dat_o,
  output logic [UW-1:0]             out_unit_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [UNIT_NUM-1:0] UNIT0_HOT = UNIT_NUM'(1);

  state_t              state, state_nx;
  logic [UW-1:0]       u;
  logic [BW-1:0]       b;
  logic                load_last;
  logic                first_run;
  logic [UNIT_NUM-1:0] end_q;
  logic [UNIT_NUM-1:0] mask_q;
  logic [UNIT_NUM-1:0] mask_src;
  logic [OBW-1:0]      acc_sel;
  logic                nxt_found;
  logic [UW-1:0]       nxt_idx;
  logic [UW-1:0]       first_idx;
  logic                flt_acc;
  logic                beat_wrap;
  logic                out_hs;
  logic                all_ended;

`ifdef CLUSTER_UNIT_MASK_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mask_q <= '0;
    end else if (state == S_IDLE && start_i) begin
      mask_q <= unit_mask_i;
    end
  end
  assign mask_src = (state == S_IDLE) ? unit_mask_i : mask_q;
`else
  assign mask_q   = '1;
  assign mask_src = '1;
`endif

  // Lowest active unit overall, and lowest active unit above the current index.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = u;
    first_idx = '0;
    for (int k = UNIT_NUM - 1; k >= 0; k--) begin
      if (mask_src[k]) first_idx = UW'(k);
      if (mask_src[k] && k > int'(u)) begin
        nxt_found = 1'b1;
        nxt_idx   = UW'(k);
      end
    end
  end

  assign flt_ready_o = (state == S_LOAD) && !load_last && (|mask_q);
  assign flt_acc     = flt_valid_i && flt_ready_o;
  assign beat_wrap   = (b == BW'(WR_BEATS - 1));
  assign out_hs      = (state == S_DRAIN) && out_ready_i;
  assign all_ended   = &(end_q | unit_chunk_end_i | ~mask_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_i) state_nx = S_LOAD;
      S_LOAD: begin
        if (~|mask_q)      state_nx = S_DONE;
        else if (load_last) state_nx = S_RUN;
      end
      S_RUN:   if (all_ended) state_nx = S_DRAIN;
      S_DRAIN: if (out_hs && !nxt_found) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      u                    <= '0;
      b                    <= '0;
      load_last            <= 1'b0;
      first_run            <= 1'b0;
      end_q                <= '0;
      acc_sel              <= '0;
      unit_flt_valid_o     <= '0;
      unit_flt_count_o     <= '0;
      unit_flt_sparsemap_o <= '0;
      unit_flt_data_o      <= '0;
    end else begin
      unit_flt_valid_o <= '0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            u         <= first_idx;
            b         <= '0;
            load_last <= 1'b0;
          end
        end
        S_LOAD: begin
          if (flt_acc) begin
            unit_flt_valid_o     <= UNIT0_HOT << u;
            unit_flt_count_o     <= b;
            unit_flt_sparsemap_o <= flt_sparsemap_i;
            unit_flt_data_o      <= flt_data_i;
            if (beat_wrap) begin
              b <= '0;
              // The index stays on the last unit so it never leaves range.
              if (nxt_found) u <= nxt_idx;
              else           load_last <= 1'b1;
            end else begin
              b <= b + 1'b1;
            end
          end
          if (load_last) begin
            end_q     <= '0;
            first_run <= 1'b1;
          end
        end
        S_RUN: begin
          first_run <= 1'b0;
          end_q     <= end_q | unit_chunk_end_i;
          if (all_ended) u <= first_idx;
        end
        S_DRAIN: begin
          if (out_hs && nxt_found) u <= nxt_idx;
        end
        S_DONE: begin
          acc_sel <= (OUT_BUF_NUM > 1) ? acc_sel + 1'b1 : '0;
        end
        default: ;
      endcase
    end
  end

  assign busy_o             = (state != S_IDLE);
  assign done_o             = (state == S_DONE);
  assign run_valid_o        = (state == S_RUN);
  assign chunk_start_o      = (state == S_RUN) && first_run;
  assign out_valid_o        = (state == S_DRAIN);
  assign out_dat_o          = (state == S_DRAIN) ? unit_out_dat_i[int'(u)*OUT_W +: OUT_W] : '0;
  assign out_unit_o         = (state == S_DRAIN) ? u : '0;
  assign acc_buf_sel_o      = acc_sel;
  assign unit_out_buf_sel_o = acc_sel;

endmodule

// File: tb/tb_cluster_sched.sv
// tb/tb_cluster_sched.sv - randomized self-checking bench for cluster_sched
module tb_cluster_sched;
  localparam int UNIT_NUM    = 8;
  localparam int BUS_SIZE    = 32;
  localparam int WR_BEATS    = 4;
  localparam int OUT_BUF_NUM = 2;
  localparam int OUT_W       = 32;
  localparam int UW          = 3;
  localparam int BW          = 2;
  localparam int OBW         = 1;
  localparam int DW          = BUS_SIZE * 8;
  localparam int NB          = UNIT_NUM * WR_BEATS;

  logic                      clk = 1'b0;
  logic                      rst_i = 1'b0;
  logic                      start_i = 1'b0;
  logic                      busy_o, done_o;
  logic                      flt_valid_i = 1'b0;
  logic                      flt_ready_o;
  logic [BUS_SIZE-1:0]       flt_sparsemap_i = '0;
  logic [DW-1:0]             flt_data_i = '0;
  logic [UNIT_NUM-1:0]       unit_flt_valid_o;
  logic [BW-1:0]             unit_flt_count_o;
  logic [BUS_SIZE-1:0]       unit_flt_sparsemap_o;
  logic [DW-1:0]             unit_flt_data_o;
  logic                      run_valid_o, chunk_start_o;
  logic [UNIT_NUM-1:0]       unit_chunk_end_i = '0;
  logic [OBW-1:0]            acc_buf_sel_o, unit_out_buf_sel_o;
  logic [UNIT_NUM*OUT_W-1:0] unit_out_dat_i = '0;
  logic                      out_valid_o;
  logic                      out_ready_i = 1'b0;
  logic [OUT_W-1:0]          out_dat_o;
  logic [UW-1:0]             out_unit_o;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_acc = 0;

  always #5 clk = ~clk;

  cluster_sched #(
    .UNIT_NUM(UNIT_NUM), .BUS_SIZE(BUS_SIZE), .WR_BEATS(WR_BEATS),
    .OUT_BUF_NUM(OUT_BUF_NUM), .OUT_W(OUT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .flt_valid_i(flt_valid_i), .flt_ready_o(flt_ready_o),
    .flt_sparsemap_i(flt_sparsemap_i), .flt_data_i(flt_data_i),
    .unit_flt_valid_o(unit_flt_valid_o), .unit_flt_count_o(unit_flt_count_o),
    .unit_flt_sparsemap_o(unit_flt_sparsemap_o), .unit_flt_data_o(unit_flt_data_o),
    .run_valid_o(run_valid_o), .chunk_start_o(chunk_start_o),
    .unit_chunk_end_i(unit_chunk_end_i), .acc_buf_sel_o(acc_buf_sel_o),
    .unit_out_buf_sel_o(unit_out_buf_sel_o), .unit_out_dat_i(unit_out_dat_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_dat_o(out_dat_o), .out_unit_o(out_unit_o)
  );

  task automatic test_reset;
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy_o, done_o, flt_ready_o, unit_flt_valid_o, unit_flt_count_o, unit_flt_sparsemap_o,
         unit_flt_data_o, run_valid_o, chunk_start_o, acc_buf_sel_o, unit_out_buf_sel_o,
         out_valid_o, out_dat_o, out_unit_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%0h exp=0", {busy_o, done_o, flt_ready_o, unit_flt_valid_o,
               run_valid_o, chunk_start_o, acc_buf_sel_o, out_valid_o, out_dat_o, out_unit_o});
    end
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({busy_o, flt_ready_o, acc_buf_sel_o} !== '0) begin
      n_bad++;
      $display("FAIL idle_after_reset got=%b exp=000", {busy_o, flt_ready_o, acc_buf_sel_o});
    end
    exp_acc = 0;
  endtask

  // One complete job. end_mode: 0 = all chunk ends held high, 1 = units 0-6 at RUN
  // cycle 1 and unit 7 at cycle 9, 2 = random pulse per unit. ready_pct < 0 alternates ready.
  task automatic do_job(input int valid_pct, input int end_mode, input int ready_pct,
                        input bit fixed_dat, input bit start_in_done);
    logic [BUS_SIZE-1:0] sm [NB];
    logic [DW-1:0]       dt [NB];
    logic [OUT_W-1:0]    od [UNIT_NUM];
    int                  endr [UNIT_NUM];
    logic [UNIT_NUM-1:0] eoh;
    logic [2:0]          exp3;
    int acc, got, cyc, last_acc, rd, w, dc;
    bit seen;

    for (int i = 0; i < NB; i++) begin
      sm[i] = $urandom();
      for (int j = 0; j < DW / 32; j++) dt[i][j*32 +: 32] = $urandom();
    end
    rd = 0;
    for (int k = 0; k < UNIT_NUM; k++) begin
      od[k] = fixed_dat ? OUT_W'(32'h100 + k) : OUT_W'($urandom());
      unit_out_dat_i[k*OUT_W +: OUT_W] = od[k];
      endr[k] = (end_mode == 0) ? 0 : (end_mode == 1) ? ((k < 7) ? 1 : 9) : $urandom_range(1, 8);
      if (endr[k] > rd) rd = endr[k];
    end
    rd = rd + 1;

    @(negedge clk);
    start_i = 1'b1;
    out_ready_i = 1'b0;
    unit_chunk_end_i = (end_mode == 0) ? '1 : '0;
    #1;
    n_cmp++;
    if (flt_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_in_start_cycle got=%b exp=0", flt_ready_o);
    end

    acc = 0; got = 0; cyc = 0; last_acc = -10; seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      start_i = 1'b0;
      flt_valid_i = (acc < NB) && ($urandom_range(0, 99) < valid_pct);
      if (acc < NB) begin
        flt_sparsemap_i = sm[acc];
        flt_data_i      = dt[acc];
      end
      #1;
      n_cmp++;
      if ({flt_ready_o, busy_o, acc_buf_sel_o} !== {(acc < NB), 1'b1, OBW'(exp_acc)}) begin
        n_bad++;
        $display("FAIL load_ready cyc=%0d got=%b exp=%b", cyc, {flt_ready_o, busy_o, acc_buf_sel_o},
                 {(acc < NB), 1'b1, OBW'(exp_acc)});
      end
      if (unit_flt_valid_o !== '0) begin
        n_cmp++;
        if (got >= NB) begin
          n_bad++;
          $display("FAIL extra_strobe got=%h exp=00", unit_flt_valid_o);
        end else begin
          eoh = '0;
          eoh[got / WR_BEATS] = 1'b1;
          if ({unit_flt_valid_o, unit_flt_count_o, unit_flt_sparsemap_o, unit_flt_data_o} !==
              {eoh, BW'(got % WR_BEATS), sm[got], dt[got]}) begin
            n_bad++;
            $display("FAIL strobe beat=%0d got=%h/%0d/%h/%h exp=%h/%0d/%h/%h", got,
                     unit_flt_valid_o, unit_flt_count_o, unit_flt_sparsemap_o, unit_flt_data_o,
                     eoh, got % WR_BEATS, sm[got], dt[got]);
          end
          got++;
        end
      end
      if (chunk_start_o === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        if ({cyc - last_acc, got, 32'(run_valid_o)} !== {32'd2, NB, 32'd1}) begin
          n_bad++;
          $display("FAIL chunk_start lat=%0d strobes=%0d run=%b exp lat=2 strobes=%0d run=1",
                   cyc - last_acc, got, run_valid_o, NB);
        end
      end
      if (flt_valid_i && flt_ready_o) begin
        last_acc = cyc;
        acc++;
      end
      cyc++;
    end
    flt_valid_i = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL chunk_start_timeout accepted=%0d strobes=%0d exp=%0d", acc, got, NB);
    end

    for (int r = 1; r <= rd; r++) begin
      @(negedge clk);
      if (end_mode != 0)
        for (int k = 0; k < UNIT_NUM; k++) unit_chunk_end_i[k] = (r == endr[k]);
      #1;
      exp3 = (r < rd) ? 3'b100 : 3'b010;
      n_cmp++;
      if ({run_valid_o, out_valid_o, chunk_start_o} !== exp3) begin
        n_bad++;
        $display("FAIL run_phase r=%0d got=%b exp=%b", r, {run_valid_o, out_valid_o, chunk_start_o}, exp3);
      end
    end
    unit_chunk_end_i = '0;
    n_cmp++;
    if ({out_dat_o, out_unit_o, unit_out_buf_sel_o} !== {od[0], UW'(0), OBW'(exp_acc)}) begin
      n_bad++;
      $display("FAIL drain_first got=%h/%0d/%0d exp=%h/0/%0d", out_dat_o, out_unit_o,
               unit_out_buf_sel_o, od[0], exp_acc);
    end

    w = 0; dc = 0;
    while (w < UNIT_NUM && dc < 200) begin
      @(negedge clk);
      dc++;
      out_ready_i = (ready_pct < 0) ? (dc % 2 == 1) : ($urandom_range(0, 99) < ready_pct);
      #1;
      n_cmp++;
      if ({out_valid_o, out_dat_o, out_unit_o, unit_out_buf_sel_o} !==
          {1'b1, od[w], UW'(w), OBW'(exp_acc)}) begin
        n_bad++;
        $display("FAIL drain_word w=%0d got=%b/%h/%0d/%0d exp=1/%h/%0d/%0d", w, out_valid_o,
                 out_dat_o, out_unit_o, unit_out_buf_sel_o, od[w], w, exp_acc);
      end
      if (out_ready_i) w++;
    end

    @(negedge clk);
    out_ready_i = 1'b0;
    start_i = start_in_done;
    #1;
    n_cmp++;
    if ({done_o, busy_o, out_valid_o} !== 3'b110) begin
      n_bad++;
      $display("FAIL done_cycle got=%b exp=110", {done_o, busy_o, out_valid_o});
    end
    @(negedge clk);
    start_i = 1'b0;
    #1;
    exp_acc = (exp_acc + 1) % OUT_BUF_NUM;
    n_cmp++;
    if ({done_o, busy_o, flt_ready_o, acc_buf_sel_o} !== {3'b000, OBW'(exp_acc)}) begin
      n_bad++;
      $display("FAIL after_done got=%b exp=000%0d", {done_o, busy_o, flt_ready_o, acc_buf_sel_o}, exp_acc);
    end
  endtask

  task automatic test_full_job;
    do_job(100, 1, -1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_job(100, 0, 100, 1'b0, 1'b1);
  endtask

  task automatic test_mid_load_reset;
    int acc = 0;
    int cyc = 0;
    @(negedge clk);
    start_i = 1'b1;
    while (acc < 10 && cyc < 50) begin
      @(negedge clk);
      start_i = 1'b0;
      flt_valid_i = 1'b1;
      flt_sparsemap_i = $urandom();
      #1;
      if (flt_ready_o) acc++;
      cyc++;
    end
    n_cmp++;
    if (acc != 10) begin
      n_bad++;
      $display("FAIL mid_load_accept got=%0d exp=10", acc);
    end
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, done_o, flt_ready_o, unit_flt_valid_o, unit_flt_count_o, unit_flt_sparsemap_o,
         unit_flt_data_o, run_valid_o, chunk_start_o, acc_buf_sel_o, unit_out_buf_sel_o,
         out_valid_o, out_dat_o, out_unit_o} !== '0) begin
      n_bad++;
      $display("FAIL async_reset_outputs got=%b/%b/%h/%0d exp=0", busy_o, flt_ready_o,
               unit_flt_valid_o, acc_buf_sel_o);
    end
    flt_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({busy_o, unit_flt_valid_o} !== '0) begin
        n_bad++;
        $display("FAIL held_reset i=%0d got=%b/%h exp=0/00", i, busy_o, unit_flt_valid_o);
      end
    end
    @(negedge clk);
    rst_i = 1'b1;
    exp_acc = 0;
    do_job(100, 1, 100, 1'b0, 1'b0);
  endtask

  task automatic test_random_jobs;
    for (int j = 0; j < 4; j++)
      do_job($urandom_range(40, 100), 2, $urandom_range(30, 100), 1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_back_to_back();
    test_mid_load_reset();
    test_random_jobs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
